// File: rtl/age_ordered_rs.sv
// Reservation station with CDB wakeup, age-matrix oldest-first select,
// full flush and selective kill of entries younger than a ROB kill point.
module age_ordered_rs #(
    parameter int NUM_SLOTS = 8,
    parameter int TAG_W     = 6,
    parameter int ROB_W     = 5,
    parameter int PAYLOAD_W = 72,
    parameter int NUM_CDB   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [TAG_W-1:0]         disp_src1_tag,
    input  logic                     disp_src1_rdy,
    input  logic [TAG_W-1:0]         disp_src2_tag,
    input  logic                     disp_src2_rdy,
    input  logic [TAG_W-1:0]         disp_dst_tag,
    input  logic [ROB_W-1:0]         disp_rob_tag,
    input  logic [PAYLOAD_W-1:0]     disp_payload,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [TAG_W-1:0]         issue_src1_tag,
    output logic [TAG_W-1:0]         issue_src2_tag,
    output logic [TAG_W-1:0]         issue_dst_tag,
    output logic [ROB_W-1:0]         issue_rob_tag,
    output logic [PAYLOAD_W-1:0]     issue_payload,
    input  logic                     flush,
    input  logic                     kill_valid,
    input  logic [ROB_W-1:0]         kill_rob_tag,
    input  logic [ROB_W-1:0]         rob_head,
    output logic [$clog2(NUM_SLOTS):0] occupancy
);

    localparam int IW = $clog2(NUM_SLOTS);
    localparam int OW = IW + 1;

    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [NUM_SLOTS-1:0] s1r_q, s1r_d;
    logic [NUM_SLOTS-1:0] s2r_q, s2r_d;
    logic [NUM_SLOTS-1:0] age_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] age_d [NUM_SLOTS];

    logic [TAG_W-1:0]     s1t_q [NUM_SLOTS];
    logic [TAG_W-1:0]     s2t_q [NUM_SLOTS];
    logic [TAG_W-1:0]     dst_q [NUM_SLOTS];
    logic [ROB_W-1:0]     rob_q [NUM_SLOTS];
    logic [PAYLOAD_W-1:0] pay_q [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] runnable;
    logic [NUM_SLOTS-1:0] blocked;
    logic [NUM_SLOTS-1:0] freed;
    logic [NUM_SLOTS-1:0] live;
    logic [IW-1:0]        sel_idx;
    logic [IW-1:0]        free_idx;
    logic                 sel_found;
    logic                 free_found;
    logic                 sel_young;
    logic                 disp_young;
    logic                 fire;
    logic                 alloc;
    logic [OW-1:0]        occ;

    function automatic logic cdb_hit(
        input logic [TAG_W-1:0]         t,
        input logic [NUM_CDB-1:0]       v,
        input logic [NUM_CDB*TAG_W-1:0] tags
    );
        logic h;
        h = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (v[k] && (tags[k*TAG_W +: TAG_W] == t)) h = 1'b1;
        end
        return h;
    endfunction

    // Ages are compared relative to the ROB head so wrap-around is handled.
    function automatic logic younger(
        input logic [ROB_W-1:0] rob,
        input logic [ROB_W-1:0] head,
        input logic [ROB_W-1:0] kill
    );
        logic [ROB_W-1:0] rel_e;
        logic [ROB_W-1:0] rel_k;
        rel_e = rob - head;
        rel_k = kill - head;
        return rel_e > rel_k;
    endfunction

    always_comb begin
        runnable  = valid_q & s1r_q & s2r_q;
        blocked   = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (runnable[j] && age_q[j][i]) blocked[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!sel_found && runnable[i] && !blocked[i]) begin
                sel_idx   = IW'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        occ        = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            occ = occ + OW'(valid_q[i]);
            if (!free_found && !valid_q[i]) begin
                free_idx   = IW'(i);
                free_found = 1'b1;
            end
        end
    end

    assign occupancy  = occ;
    assign disp_ready = (occ != OW'(NUM_SLOTS));
    assign sel_young  = younger(rob_q[sel_idx], rob_head, kill_rob_tag);
    assign disp_young = younger(disp_rob_tag, rob_head, kill_rob_tag);

    assign issue_valid = sel_found && !flush && !(kill_valid && sel_young);
    assign fire        = issue_valid && issue_ready;
    assign alloc       = disp_valid && disp_ready && !flush
                      && !(kill_valid && disp_young);

    assign issue_src1_tag = s1t_q[sel_idx];
    assign issue_src2_tag = s2t_q[sel_idx];
    assign issue_dst_tag  = dst_q[sel_idx];
    assign issue_rob_tag  = rob_q[sel_idx];
    assign issue_payload  = pay_q[sel_idx];

    always_comb begin
        freed = '0;
        if (fire) freed[sel_idx] = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (kill_valid && valid_q[i]
                && younger(rob_q[i], rob_head, kill_rob_tag)) begin
                freed[i] = 1'b1;
            end
        end
        live    = valid_q & ~freed;
        valid_d = flush ? '0 : live;
        s1r_d   = s1r_q;
        s2r_d   = s2r_q;
        age_d   = age_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (cdb_hit(s1t_q[i], cdb_valid, cdb_tag)) s1r_d[i] = 1'b1;
            if (cdb_hit(s2t_q[i], cdb_valid, cdb_tag)) s2r_d[i] = 1'b1;
        end
        if (alloc) begin
            valid_d[free_idx] = 1'b1;
            s1r_d[free_idx]   = disp_src1_rdy
                             || cdb_hit(disp_src1_tag, cdb_valid, cdb_tag);
            s2r_d[free_idx]   = disp_src2_rdy
                             || cdb_hit(disp_src2_tag, cdb_valid, cdb_tag);
            age_d[free_idx]   = '0;
            for (int j = 0; j < NUM_SLOTS; j++) begin
                age_d[j][free_idx] = live[j];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            s1r_q   <= '0;
            s2r_q   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                age_q[i] <= '0;
                s1t_q[i] <= '0;
                s2t_q[i] <= '0;
                dst_q[i] <= '0;
                rob_q[i] <= '0;
                pay_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            s1r_q   <= s1r_d;
            s2r_q   <= s2r_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                age_q[i] <= age_d[i];
            end
            if (alloc) begin
                s1t_q[free_idx] <= disp_src1_tag;
                s2t_q[free_idx] <= disp_src2_tag;
                dst_q[free_idx] <= disp_dst_tag;
                rob_q[free_idx] <= disp_rob_tag;
                pay_q[free_idx] <= disp_payload;
            end
        end
    end

endmodule

// File: tb/tb_age_ordered_rs.sv
// Directed bench for age_ordered_rs: dispatch, age order, wakeup,
// full/drain, wrapped kill, flush and asynchronous reset.
module tb_age_ordered_rs;

    logic        clk;
    logic        reset_n;
    logic        disp_valid;
    logic        disp_ready;
    logic [5:0]  disp_src1_tag;
    logic        disp_src1_rdy;
    logic [5:0]  disp_src2_tag;
    logic        disp_src2_rdy;
    logic [5:0]  disp_dst_tag;
    logic [4:0]  disp_rob_tag;
    logic [71:0] disp_payload;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  issue_src1_tag;
    logic [5:0]  issue_src2_tag;
    logic [5:0]  issue_dst_tag;
    logic [4:0]  issue_rob_tag;
    logic [71:0] issue_payload;
    logic        flush;
    logic        kill_valid;
    logic [4:0]  kill_rob_tag;
    logic [4:0]  rob_head;
    logic [3:0]  occupancy;

    int tests = 0;
    int fails = 0;

    age_ordered_rs dut (
        .clk(clk), .reset_n(reset_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
        .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
        .disp_dst_tag(disp_dst_tag), .disp_rob_tag(disp_rob_tag),
        .disp_payload(disp_payload),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
        .issue_dst_tag(issue_dst_tag), .issue_rob_tag(issue_rob_tag),
        .issue_payload(issue_payload),
        .flush(flush), .kill_valid(kill_valid),
        .kill_rob_tag(kill_rob_tag), .rob_head(rob_head),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid  = 1'b0;
        cdb_valid   = '0;
        cdb_tag     = '0;
        issue_ready = 1'b0;
        flush       = 1'b0;
        kill_valid  = 1'b0;
    endtask

    task automatic disp(input int rob, input int t1, input int r1,
                        input int t2, input int r2);
        disp_valid    = 1'b1;
        disp_rob_tag  = 5'(rob);
        disp_src1_tag = 6'(t1);
        disp_src1_rdy = 1'(r1);
        disp_src2_tag = 6'(t2);
        disp_src2_rdy = 1'(r2);
        disp_dst_tag  = 6'(rob + 32);
        disp_payload  = 72'(rob) | (72'hA5 << 64);
    endtask

    task automatic test_reset();
        idle();
        kill_rob_tag = '0;
        rob_head     = '0;
        disp(0, 0, 0, 0, 0);
        disp_valid = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        tests++;
        if (occupancy !== 4'd0) begin fails++;
            $display("FAIL reset_occ got %0d want 0", occupancy); end
        tests++;
        if (disp_ready !== 1'b1) begin fails++;
            $display("FAIL reset_disp_ready got %b want 1", disp_ready); end
        tests++;
        if (issue_valid !== 1'b0) begin fails++;
            $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
        tests++;
        if (issue_payload !== 72'd0 || issue_rob_tag !== 5'd0) begin fails++;
            $display("FAIL reset_data got %h/%0d want 0/0",
                     issue_payload, issue_rob_tag); end
    endtask

    task automatic test_single();
        step();
        disp(3, 1, 1, 2, 1);
        #1;
        tests++;
        if (issue_valid !== 1'b0) begin fails++;
            $display("FAIL no_bypass got %b want 0", issue_valid); end
        step(); idle(); #1;
        tests++;
        if (issue_valid !== 1'b1 || issue_rob_tag !== 5'd3) begin fails++;
            $display("FAIL single_issue got v=%b rob=%0d want v=1 rob=3",
                     issue_valid, issue_rob_tag); end
        tests++;
        if (issue_dst_tag !== 6'd35 || issue_payload !== ((72'hA5 << 64) | 72'd3))
        begin fails++;
            $display("FAIL single_data got dst=%0d pay=%h want dst=35",
                     issue_dst_tag, issue_payload); end
        tests++;
        if (occupancy !== 4'd1) begin fails++;
            $display("FAIL single_occ got %0d want 1", occupancy); end
        issue_ready = 1'b1;
        step(); idle(); #1;
        tests++;
        if (occupancy !== 4'd0 || issue_valid !== 1'b0) begin fails++;
            $display("FAIL single_drain got occ=%0d v=%b want 0/0",
                     occupancy, issue_valid); end
    endtask

    task automatic test_age_order();
        logic [4:0] exp [3];
        exp = '{5'd5, 5'd6, 5'd7};
        disp(5, 9, 0, 3, 1); step();
        disp(6, 1, 1, 2, 1); step();
        disp(7, 1, 1, 2, 1); step();
        idle(); #1;
        tests++;
        if (issue_valid !== 1'b1 || issue_rob_tag !== 5'd6) begin fails++;
            $display("FAIL age_first got v=%b rob=%0d want v=1 rob=6",
                     issue_valid, issue_rob_tag); end
        tests++;
        if (occupancy !== 4'd3) begin fails++;
            $display("FAIL age_occ got %0d want 3", occupancy); end
        cdb_valid = 2'b10;
        cdb_tag   = {6'd9, 6'd0};
        step(); idle(); #1;
        tests++;
        if (issue_rob_tag !== 5'd5 || issue_src1_tag !== 6'd9) begin fails++;
            $display("FAIL age_wake got rob=%0d s1=%0d want rob=5 s1=9",
                     issue_rob_tag, issue_src1_tag); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (issue_valid !== 1'b1 || issue_rob_tag !== exp[i]) begin fails++;
                $display("FAIL age_drain%0d got v=%b rob=%0d want rob=%0d",
                         i, issue_valid, issue_rob_tag, exp[i]); end
            issue_ready = 1'b1;
            step(); idle(); #1;
        end
        tests++;
        if (occupancy !== 4'd0) begin fails++;
            $display("FAIL age_empty got %0d want 0", occupancy); end
    endtask

    task automatic test_same_cycle_wakeup();
        disp(8, 1, 1, 12, 0);
        cdb_valid = 2'b01;
        cdb_tag   = {6'd0, 6'd12};
        step(); idle(); #1;
        tests++;
        if (issue_valid !== 1'b1 || issue_rob_tag !== 5'd8) begin fails++;
            $display("FAIL same_cyc_wake got v=%b rob=%0d want v=1 rob=8",
                     issue_valid, issue_rob_tag); end
        issue_ready = 1'b1;
        step(); idle();
        cdb_valid = 2'b01;
        cdb_tag   = {6'd0, 6'd12};
        step(); idle();
        disp(9, 1, 1, 12, 0);
        step(); idle(); #1;
        tests++;
        if (issue_valid !== 1'b0 || occupancy !== 4'd1) begin fails++;
            $display("FAIL stale_wait got v=%b occ=%0d want v=0 occ=1",
                     issue_valid, occupancy); end
        cdb_valid = 2'b10;
        cdb_tag   = {6'd12, 6'd0};
        step(); idle(); #1;
        tests++;
        if (issue_valid !== 1'b1 || issue_rob_tag !== 5'd9) begin fails++;
            $display("FAIL late_wake got v=%b rob=%0d want v=1 rob=9",
                     issue_valid, issue_rob_tag); end
        issue_ready = 1'b1;
        step(); idle();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            disp(10 + i, 20 + i, 0, 0, 1);
            step();
        end
        disp(18, 1, 1, 2, 1);
        #1;
        tests++;
        if (disp_ready !== 1'b0 || occupancy !== 4'd8) begin fails++;
            $display("FAIL full_state got rdy=%b occ=%0d want rdy=0 occ=8",
                     disp_ready, occupancy); end
        step(); idle(); #1;
        tests++;
        if (occupancy !== 4'd8 || issue_valid !== 1'b0) begin fails++;
            $display("FAIL full_ignore got occ=%0d v=%b want occ=8 v=0",
                     occupancy, issue_valid); end
        for (int k = 0; k < 4; k++) begin
            cdb_valid = 2'b11;
            cdb_tag   = {6'(21 + 2 * k), 6'(20 + 2 * k)};
            step(); idle();
        end
        #1;
        tests++;
        if (issue_rob_tag !== 5'd10 || disp_ready !== 1'b0) begin fails++;
            $display("FAIL full_first got rob=%0d rdy=%b want rob=10 rdy=0",
                     issue_rob_tag, disp_ready); end
        issue_ready = 1'b1;
        disp(19, 1, 1, 2, 1);
        step(); idle(); #1;
        tests++;
        if (disp_ready !== 1'b1 || occupancy !== 4'd7) begin fails++;
            $display("FAIL full_reopen got rdy=%b occ=%0d want rdy=1 occ=7",
                     disp_ready, occupancy); end
        for (int i = 1; i < 8; i++) begin
            tests++;
            if (issue_valid !== 1'b1 || issue_rob_tag !== 5'(10 + i)) begin
                fails++;
                $display("FAIL full_drain%0d got v=%b rob=%0d want rob=%0d",
                         i, issue_valid, issue_rob_tag, 10 + i); end
            issue_ready = 1'b1;
            step(); idle(); #1;
        end
        tests++;
        if (occupancy !== 4'd0) begin fails++;
            $display("FAIL full_empty got %0d want 0", occupancy); end
    endtask

    task automatic test_kill_wrap();
        logic [4:0] exp [3];
        exp = '{5'd30, 5'd31, 5'd0};
        rob_head = 5'd30;
        disp(30, 40, 0, 0, 1); step();
        disp(31, 40, 0, 0, 1); step();
        disp(0, 40, 0, 0, 1); step();
        disp(1, 40, 0, 0, 1); step();
        disp(2, 40, 0, 0, 1); step();
        idle(); #1;
        tests++;
        if (occupancy !== 4'd5) begin fails++;
            $display("FAIL kill_pre_occ got %0d want 5", occupancy); end
        kill_valid   = 1'b1;
        kill_rob_tag = 5'd0;
        disp(3, 1, 1, 2, 1);
        step(); idle(); #1;
        tests++;
        if (occupancy !== 4'd3 || issue_valid !== 1'b0) begin fails++;
            $display("FAIL kill_occ got occ=%0d v=%b want occ=3 v=0",
                     occupancy, issue_valid); end
        cdb_valid = 2'b01;
        cdb_tag   = {6'd0, 6'd40};
        step(); idle(); #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (issue_valid !== 1'b1 || issue_rob_tag !== exp[i]) begin fails++;
                $display("FAIL kill_drain%0d got v=%b rob=%0d want rob=%0d",
                         i, issue_valid, issue_rob_tag, exp[i]); end
            issue_ready = 1'b1;
            step(); idle(); #1;
        end
        rob_head = 5'd0;
        disp(4, 50, 0, 0, 1); step();
        disp(5, 1, 1, 2, 1); step();
        idle(); #1;
        tests++;
        if (issue_valid !== 1'b1 || issue_rob_tag !== 5'd5) begin fails++;
            $display("FAIL kill2_pre got v=%b rob=%0d want v=1 rob=5",
                     issue_valid, issue_rob_tag); end
        kill_valid   = 1'b1;
        kill_rob_tag = 5'd4;
        issue_ready  = 1'b1;
        #1;
        tests++;
        if (issue_valid !== 1'b0) begin fails++;
            $display("FAIL kill_force got %b want 0", issue_valid); end
        step(); idle(); #1;
        tests++;
        if (occupancy !== 4'd1 || issue_valid !== 1'b0) begin fails++;
            $display("FAIL kill_survive got occ=%0d v=%b want occ=1 v=0",
                     occupancy, issue_valid); end
        cdb_valid = 2'b01;
        cdb_tag   = {6'd0, 6'd50};
        step(); idle(); #1;
        tests++;
        if (issue_valid !== 1'b1 || issue_rob_tag !== 5'd4) begin fails++;
            $display("FAIL kill_equal got v=%b rob=%0d want v=1 rob=4",
                     issue_valid, issue_rob_tag); end
        issue_ready = 1'b1;
        step(); idle();
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 4; i++) begin
            disp(i, 1, 1, 2, 1);
            step();
        end
        idle(); #1;
        tests++;
        if (occupancy !== 4'd4 || issue_rob_tag !== 5'd1) begin fails++;
            $display("FAIL flush_pre got occ=%0d rob=%0d want occ=4 rob=1",
                     occupancy, issue_rob_tag); end
        flush       = 1'b1;
        issue_ready = 1'b1;
        disp(5, 1, 1, 2, 1);
        #1;
        tests++;
        if (issue_valid !== 1'b0) begin fails++;
            $display("FAIL flush_force got %b want 0", issue_valid); end
        step(); idle(); #1;
        tests++;
        if (occupancy !== 4'd0 || issue_valid !== 1'b0 || disp_ready !== 1'b1)
        begin fails++;
            $display("FAIL flush_after got occ=%0d v=%b rdy=%b want 0/0/1",
                     occupancy, issue_valid, disp_ready); end
    endtask

    task automatic test_async_reset();
        disp(6, 1, 1, 2, 1); step();
        disp(7, 1, 1, 2, 1); step();
        idle(); #1;
        tests++;
        if (occupancy !== 4'd2 || issue_valid !== 1'b1) begin fails++;
            $display("FAIL areset_pre got occ=%0d v=%b want occ=2 v=1",
                     occupancy, issue_valid); end
        #1;
        reset_n = 1'b0;
        #1;
        tests++;
        if (occupancy !== 4'd0 || issue_valid !== 1'b0 || disp_ready !== 1'b1)
        begin fails++;
            $display("FAIL areset_ctl got occ=%0d v=%b rdy=%b want 0/0/1",
                     occupancy, issue_valid, disp_ready); end
        tests++;
        if (issue_rob_tag !== 5'd0 || issue_payload !== 72'd0) begin fails++;
            $display("FAIL areset_data got rob=%0d pay=%h want 0/0",
                     issue_rob_tag, issue_payload); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_age_order();
        test_same_cycle_wakeup();
        test_full();
        test_kill_wrap();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
